// File: rtl/hdr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : hdr_pkg                                                      |
// | Description : Shared types and constants for the HDR exposure merge path:  |
// |               FSM state encoding, fixed-point geometry, saturation code    |
// |               and the hat-weight helper w(z) = min(z, 2^PIX_W-1-z).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hdr_pkg;

  // Default sample width and fixed-point layout of the divider result.
  localparam int PIX_W_DEF = 8;
  localparam int FRAC_BITS = 4;

  // Saturated 8.4 output code (all ones).
  localparam int SAT_VALUE = 32'h0000_0FFF;

  // Merge FSM states.
  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  // Hat weight: distance of z to the nearer end of the code range, so that
  // clipped (very dark / very bright) samples contribute little or nothing.
  function automatic logic [15:0] hat_weight(input logic [15:0] z, input int pix_w);
    logic [15:0] zmax;
    logic [15:0] mirror;
    zmax   = 16'((32'd1 << pix_w) - 32'd1);
    mirror = zmax - z;
    return (z < mirror) ? z : mirror;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdr_hat_weight.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hdr_hat_weight                                               |
// | Description : Combinational hat weight w = min(z, 2^PIX_W-1-z).            |
// |   z_i : PIX_W-bit exposure sample                                          |
// |   w_o : PIX_W-bit weight (never exceeds 2^(PIX_W-1)-1)                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hdr_hat_weight
  import hdr_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] z_i,
  output logic [PIX_W-1:0] w_o
);

  assign w_o = PIX_W'(hat_weight(16'(z_i), PIX_W));

endmodule
`default_nettype wire

// File: rtl/hdr_merge_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hdr_merge_accum                                              |
// | Description : Collects EXPOSURES samples of one pixel, accumulates         |
// |               num = sum(w*z) and den = sum(w), issues one divide request   |
// |               and emits the merged radiance pixel in 8.4 fixed point.      |
// | Ports       :                                                              |
// |   clk, rst_n           clock, asynchronous active-low reset                |
// |   in_valid/in_data     exposure sample stream (exposure 0 first)           |
// |   in_ready             high while collecting samples                       |
// |   div_a/div_b          numerator / denominator to the divider              |
// |   div_valid            one-cycle divide request                            |
// |   div_q/div_done       divider quotient (4 fraction bits) and its strobe   |
// |   div_ovf/div_inv      divider overflow / divide-by-zero flags             |
// |   px_out/px_valid      merged pixel and its one-cycle strobe               |
// |   px_err               error flag, qualified by px_valid                   |
// | Options     : define HDR_DIV_TIMEOUT_EN to bound the divider wait to       |
// |               TIMEOUT cycles (saturated pixel with px_err on expiry).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hdr_merge_accum
  import hdr_pkg::*;
#(
  parameter int EXPOSURES = 3,
  parameter int PIX_W     = PIX_W_DEF,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [PIX_W-1:0]           in_data,
  output logic                       in_ready,
  output logic [31:0]                div_a,
  output logic [31:0]                div_b,
  output logic                       div_valid,
  input  logic [31:0]                div_q,
  input  logic                       div_done,
  input  logic                       div_ovf,
  input  logic                       div_inv,
  output logic [PIX_W+FRAC_BITS-1:0] px_out,
  output logic                       px_valid,
  output logic                       px_err
);

  localparam int PX_W  = PIX_W + FRAC_BITS;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(EXPOSURES - 1);
  localparam logic [PX_W-1:0]  c_SAT  = (PIX_W == PIX_W_DEF) ? PX_W'(SAT_VALUE) : '1;
  // Largest integer radiance with zero fraction, used when every weight is 0.
  localparam logic [PX_W-1:0]  c_MAX_INT = {{PIX_W{1'b1}}, {FRAC_BITS{1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         num_q, num_d;
  logic [31:0]         den_q, den_d;
  logic                last_hi_q, last_hi_d;
  logic [PX_W-1:0]     px_out_q, px_out_d;
  logic                px_err_q, px_err_d;

  logic [PIX_W-1:0]    w_weight;
  logic [2*PIX_W-1:0]  w_prod;
  logic                w_accept;
  logic                w_q_big;
  logic                w_timeout;

  hdr_hat_weight #(
    .PIX_W (PIX_W)
  ) u_hat (
    .z_i (in_data),
    .w_o (w_weight)
  );

  assign w_prod   = (2*PIX_W)'(w_weight) * (2*PIX_W)'(in_data);
  assign w_accept = in_valid && in_ready;
  // Quotient does not fit the 8.4 output when any integer bit above PIX_W is set.
  assign w_q_big  = (div_q >> PX_W) != 32'd0;

`ifdef HDR_DIV_TIMEOUT_EN
  logic [15:0] tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q == ST_WAIT && !div_done) begin
      tmo_q <= tmo_q + 16'd1;
    end else begin
      tmo_q <= '0;
    end
  end

  // Fires on the TIMEOUT-th consecutive WAIT cycle.
  assign w_timeout = (state_q == ST_WAIT) && (tmo_q == 16'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM:  if (w_accept && cnt_q == c_LAST) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = (den_q == 32'd0) ? ST_OUTPUT : ST_WAIT;
      ST_WAIT:   if (div_done || w_timeout) state_d = ST_OUTPUT;
      ST_OUTPUT: state_d = ST_ACCUM;
      default:   state_d = ST_ACCUM;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    div_valid = (state_q == ST_ISSUE) && (den_q != 32'd0);
    px_valid  = (state_q == ST_OUTPUT);
  end

  // Accumulators are only cleared in OUTPUT, so they double as the stable
  // divider operands for the whole ISSUE/WAIT window.
  assign div_a  = num_q;
  assign div_b  = den_q;
  assign px_out = px_out_q;
  assign px_err = px_err_q;

  // ---------------------------------------------------------------- datapath
  always_comb begin
    cnt_d     = cnt_q;
    num_d     = num_q;
    den_d     = den_q;
    last_hi_d = last_hi_q;
    px_out_d  = px_out_q;
    px_err_d  = px_err_q;
    case (state_q)
      ST_ACCUM: begin
        if (w_accept) begin
          cnt_d     = cnt_q + CNT_W'(1);
          num_d     = num_q + 32'(w_prod);
          den_d     = den_q + 32'(w_weight);
          last_hi_d = in_data[PIX_W-1];
        end
      end
      ST_ISSUE: begin
        // All samples clipped: pick black or full white from the last exposure.
        if (den_q == 32'd0) begin
          px_out_d = last_hi_q ? c_MAX_INT : '0;
          px_err_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (div_done) begin
          if (div_inv) begin
            px_out_d = c_SAT;
            px_err_d = 1'b1;
          end else if (div_ovf || w_q_big) begin
            px_out_d = c_SAT;
            px_err_d = 1'b0;
          end else begin
            px_out_d = div_q[PX_W-1:0];
            px_err_d = 1'b0;
          end
        end else if (w_timeout) begin
          px_out_d = c_SAT;
          px_err_d = 1'b1;
        end
      end
      ST_OUTPUT: begin
        cnt_d     = '0;
        num_d     = '0;
        den_d     = '0;
        last_hi_d = 1'b0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      num_q     <= '0;
      den_q     <= '0;
      last_hi_q <= 1'b0;
      px_out_q  <= '0;
      px_err_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      den_q     <= den_d;
      last_hi_q <= last_hi_d;
      px_out_q  <= px_out_d;
      px_err_q  <= px_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdr_merge_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hdr_merge_accum                                           |
// | Description : Directed self-checking bench for hdr_merge_accum. The bench  |
// |               plays the divider, models the expected pixel for every       |
// |               sample triple and queues it for comparison at px_valid.      |
// |               Timeout scenario is included when HDR_DIV_TIMEOUT_EN is set. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hdr_merge_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_valid;
  logic [31:0] div_q;
  logic        div_done;
  logic        div_ovf;
  logic        div_inv;
  logic [11:0] px_out;
  logic        px_valid;
  logic        px_err;

  int n_checks = 0;
  int n_fail   = 0;
  int px_cnt   = 0;
  int div_cnt  = 0;

  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  hdr_merge_accum #(
    .EXPOSURES (3),
    .PIX_W     (8),
    .TIMEOUT   (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_valid (div_valid),
    .div_q     (div_q),
    .div_done  (div_done),
    .div_ovf   (div_ovf),
    .div_inv   (div_inv),
    .px_out    (px_out),
    .px_valid  (px_valid),
    .px_err    (px_err)
  );

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (px_valid)  px_cnt  <= px_cnt + 1;
    if (div_valid) div_cnt <= div_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int hw(input int z);
    return (z < 128) ? z : 255 - z;
  endfunction

  // mode: 0 normal, 1 div_inv, 2 div_ovf, 3 oversized quotient, 4 no div_done
  task automatic run_pixel(input int z0, input int z1, input int z2,
                           input int mode, input bit hold, input int hold_z);
    int          z[3];
    int          num, den, q, n, dc0, pc0;
    logic [11:0] ep;
    logic        ee;
    logic [12:0] e;
    z   = '{z0, z1, z2};
    num = 0;
    den = 0;
    for (int i = 0; i < 3; i++) begin
      num += hw(z[i]) * z[i];
      den += hw(z[i]);
    end
    q  = (den != 0) ? (num * 16) / den : 0;
    ee = 1'b0;
    if (den == 0) begin
      ep = (z2 >= 128) ? 12'hFF0 : 12'h000;
    end else begin
      case (mode)
        0:       ep = (q > 4095) ? 12'hFFF : 12'(q);
        1, 4:    begin ep = 12'hFFF; ee = 1'b1; end
        default: ep = 12'hFFF;
      endcase
    end
    exp_q.push_back({ee, ep});
    dc0 = div_cnt;
    pc0 = px_cnt;

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(z[i]);
      n = 0;
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = hold;
    in_data  = hold ? 8'(hold_z) : 8'd0;
    chk("in_ready_issue", 32'(in_ready), 32'd0);

    if (den != 0) begin
      chk("div_valid_issue", 32'(div_valid), 32'd1);
      chk("div_a", div_a, 32'(num));
      chk("div_b", div_b, 32'(den));
      tick();
      chk("div_valid_wait", 32'(div_valid), 32'd0);
      if (mode == 4) begin
        n = 0;
        while (!px_valid && n < 200) begin
          tick();
          n++;
        end
        chk("timeout_cycles", 32'(n), 32'd64);
      end else begin
        repeat (3) tick();
        chk("in_ready_wait_st", 32'(in_ready), 32'd0);
        chk("div_a_stable", div_a, 32'(num));
        chk("div_b_stable", div_b, 32'(den));
        div_q    = (mode == 3) ? 32'h0001_0000 : ((mode == 1) ? 32'd0 : 32'(q));
        div_inv  = (mode == 1);
        div_ovf  = (mode == 2);
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        div_inv  = 1'b0;
        div_ovf  = 1'b0;
      end
    end else begin
      chk("no_div_valid", 32'(div_valid), 32'd0);
      chk("px_valid_early", 32'(px_valid), 32'd0);
      tick();
    end

    chk("px_valid", 32'(px_valid), 32'd1);
    e = exp_q.pop_front();
    chk("px_out", 32'(px_out), 32'(e[11:0]));
    chk("px_err", 32'(px_err), 32'(e[12]));
    chk("div_req_count", 32'(div_cnt - dc0), (den != 0) ? 32'd1 : 32'd0);
    tick();
    chk("px_valid_pulse", 32'(px_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("px_out_hold", 32'(px_out), 32'(e[11:0]));
    chk("px_count", 32'(px_cnt - pc0), 32'd1);
  endtask

  initial begin
    int pc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    div_q    = '0;
    div_done = 1'b0;
    div_ovf  = 1'b0;
    div_inv  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_div_valid", 32'(div_valid), 32'd0);
    chk("rst_px_valid", 32'(px_valid), 32'd0);
    chk("rst_px_err", 32'(px_err), 32'd0);
    chk("rst_px_out", 32'(px_out), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    rst_n = 1'b1;
    tick();

    run_pixel(100, 100, 100, 0, 1'b0, 0);   // 30000/300 -> 0x640
    run_pixel(64, 128, 200, 0, 1'b0, 0);    // 31352/246 -> 0x7F7
    run_pixel(0, 255, 255, 0, 1'b0, 0);     // den 0, bright -> 0xFF0
    run_pixel(0, 0, 0, 0, 1'b0, 0);         // den 0, dark -> 0x000

    // Stray div_done while collecting samples.
    pc       = px_cnt;
    div_q    = 32'h123;
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    repeat (2) tick();
    chk("stray_done_accum", 32'(px_cnt - pc), 32'd0);

    // Backpressure: 40 held valid through ISSUE/WAIT/OUTPUT, consumed once.
    run_pixel(10, 20, 30, 0, 1'b1, 40);
    run_pixel(40, 50, 60, 0, 1'b0, 0);

    run_pixel(100, 100, 100, 2, 1'b0, 0);   // overflow flag
    run_pixel(64, 128, 200, 3, 1'b0, 0);    // quotient too wide
    run_pixel(200, 50, 90, 1, 1'b0, 0);     // divide-by-zero flag

    // Reset while waiting on the divider.
    pc = px_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'd100;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_div_valid", 32'(div_valid), 32'd0);
    chk("mid_rst_px_valid", 32'(px_valid), 32'd0);
    chk("mid_rst_px_err", 32'(px_err), 32'd0);
    chk("mid_rst_px_out", 32'(px_out), 32'd0);
    chk("mid_rst_div_a", div_a, 32'd0);
    chk("mid_rst_div_b", div_b, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    div_q    = 32'h640;
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    repeat (3) tick();
    chk("post_rst_no_px", 32'(px_cnt - pc), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_pixel(1, 2, 3, 0, 1'b0, 0);         // 224/6 -> 0x025

`ifdef HDR_DIV_TIMEOUT_EN
    run_pixel(100, 100, 100, 4, 1'b0, 0);
    pc       = px_cnt;
    div_q    = 32'h640;
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    repeat (3) tick();
    chk("stray_done_after_tmo", 32'(px_cnt - pc), 32'd0);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
